// File: rtl/calc1_port_driver.sv
// Request-side driver for one calc1 port: queues {cmd, op1, op2}, plays each request onto the
// two-cycle calc1 protocol, and hands the response (or a timeout) back over valid/ready.
module calc1_port_driver #(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 64
) (
    input  logic        c_clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [0:3]  req_cmd,
    input  logic [0:31] req_op1,
    input  logic [0:31] req_op2,
    output logic [0:3]  duv_cmd,
    output logic [0:31] duv_data,
    input  logic [0:1]  duv_resp,
    input  logic [0:31] duv_rdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [0:1]  rsp_resp,
    output logic [0:31] rsp_data,
    output logic        rsp_timeout,
    output logic        stray_err,
    output logic        busy
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(TIMEOUT);

    typedef enum logic [2:0] {S_IDLE, S_SEND1, S_SEND2, S_WAIT, S_HOLD} state_t;

    logic [67:0]   r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          w_full;
    logic          w_empty;
    logic          w_push;
    logic          w_pop;
    logic [3:0]    w_head_cmd;
    logic [31:0]   w_head_op1;
    logic [31:0]   w_head_op2;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [CW-1:0] r_wait_cnt;
    logic [CW-1:0] w_wait_cnt_nxt;
    logic [31:0]   r_op2;
    logic [3:0]    r_duv_cmd;
    logic [3:0]    w_duv_cmd_nxt;
    logic [31:0]   r_duv_data;
    logic [31:0]   w_duv_data_nxt;
    logic          r_rsp_valid;
    logic          w_rsp_valid_nxt;
    logic [1:0]    r_rsp_resp;
    logic [1:0]    w_rsp_resp_nxt;
    logic [31:0]   r_rsp_data;
    logic [31:0]   w_rsp_data_nxt;
    logic          r_rsp_timeout;
    logic          w_rsp_timeout_nxt;
    logic          r_stray;

    // Full/empty come from the registered count, so a pop never frees a slot in the same cycle.
    assign w_full  = (r_count == (AW+1)'(DEPTH));
    assign w_empty = (r_count == '0);
    assign w_push  = req_valid && !w_full;
    assign w_pop   = (r_state == S_IDLE) && !w_empty;
    assign {w_head_cmd, w_head_op1, w_head_op2} = r_mem[r_rd_ptr];

    always_ff @(posedge c_clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge c_clk) begin
        if (w_push) r_mem[r_wr_ptr] <= {req_cmd, req_op1, req_op2};
        if (w_pop)  r_op2 <= w_head_op2;
    end

    always_ff @(posedge c_clk or posedge reset) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_wait_cnt    <= '0;
            r_duv_cmd     <= '0;
            r_duv_data    <= '0;
            r_rsp_valid   <= 1'b0;
            r_rsp_resp    <= '0;
            r_rsp_data    <= '0;
            r_rsp_timeout <= 1'b0;
            r_stray       <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_wait_cnt    <= w_wait_cnt_nxt;
            r_duv_cmd     <= w_duv_cmd_nxt;
            r_duv_data    <= w_duv_data_nxt;
            r_rsp_valid   <= w_rsp_valid_nxt;
            r_rsp_resp    <= w_rsp_resp_nxt;
            r_rsp_data    <= w_rsp_data_nxt;
            r_rsp_timeout <= w_rsp_timeout_nxt;
            r_stray       <= r_stray || ((duv_resp != 2'd0) && (r_state != S_WAIT));
        end
    end

    always_comb begin
        w_state_nxt       = r_state;
        w_wait_cnt_nxt    = r_wait_cnt;
        w_duv_cmd_nxt     = '0;
        w_duv_data_nxt    = '0;
        w_rsp_valid_nxt   = r_rsp_valid;
        w_rsp_resp_nxt    = r_rsp_resp;
        w_rsp_data_nxt    = r_rsp_data;
        w_rsp_timeout_nxt = r_rsp_timeout;
        case (r_state)
            // A popped cmd==0 entry is simply discarded and the FSM stays here.
            S_IDLE: begin
                if (!w_empty && (w_head_cmd != 4'd0)) begin
                    w_duv_cmd_nxt  = w_head_cmd;
                    w_duv_data_nxt = w_head_op1;
                    w_state_nxt    = S_SEND1;
                end
            end
            S_SEND1: begin
                w_duv_data_nxt = r_op2;
                w_state_nxt    = S_SEND2;
            end
            S_SEND2: begin
                w_wait_cnt_nxt = '0;
                w_state_nxt    = S_WAIT;
            end
            S_WAIT: begin
                if (duv_resp != 2'd0) begin
                    w_rsp_valid_nxt   = 1'b1;
                    w_rsp_resp_nxt    = duv_resp;
                    w_rsp_data_nxt    = duv_rdata;
                    w_rsp_timeout_nxt = 1'b0;
                    w_state_nxt       = S_HOLD;
                end else if (r_wait_cnt == CW'(TIMEOUT - 1)) begin
                    w_rsp_valid_nxt   = 1'b1;
                    w_rsp_resp_nxt    = '0;
                    w_rsp_data_nxt    = '0;
                    w_rsp_timeout_nxt = 1'b1;
                    w_state_nxt       = S_HOLD;
                end else begin
                    w_wait_cnt_nxt = r_wait_cnt + 1'b1;
                end
            end
            S_HOLD: begin
                if (rsp_ready) begin
                    w_rsp_valid_nxt = 1'b0;
                    w_state_nxt     = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign req_ready   = !w_full;
    assign busy        = !w_empty || (r_state != S_IDLE);
    assign duv_cmd     = r_duv_cmd;
    assign duv_data    = r_duv_data;
    assign rsp_valid   = r_rsp_valid;
    assign rsp_resp    = r_rsp_resp;
    assign rsp_data    = r_rsp_data;
    assign rsp_timeout = r_rsp_timeout;
    assign stray_err   = r_stray;

endmodule

// File: tb/tb_calc1_port_driver.sv
// Bench for calc1_port_driver: a calc1 responder, a transaction-level model of the driver,
// and one negedge compare process.
module tb_calc1_port_driver;
    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 16;
    localparam int NLIT    = 10;

    localparam logic [1:0]  LIT_RESP [NLIT] = '{2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1, 2'd1, 2'd1, 2'd1, 2'd0};
    localparam logic [31:0] LIT_DATA [NLIT] = '{32'h0200_0000, 32'd0, 32'd0, 32'd0, 32'd0, 32'd1, 32'd3, 32'd5, 32'd7, 32'd0};
    localparam logic        LIT_TO   [NLIT] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

    logic        c_clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [3:0]  req_cmd = '0;
    logic [31:0] req_op1 = '0;
    logic [31:0] req_op2 = '0;
    logic [3:0]  duv_cmd;
    logic [31:0] duv_data;
    logic [1:0]  duv_resp = '0;
    logic [31:0] duv_rdata = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [1:0]  rsp_resp;
    logic [31:0] rsp_data;
    logic        rsp_timeout;
    logic        stray_err;
    logic        busy;

    calc1_port_driver #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .c_clk(c_clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_cmd(req_cmd), .req_op1(req_op1), .req_op2(req_op2),
        .duv_cmd(duv_cmd), .duv_data(duv_data), .duv_resp(duv_resp), .duv_rdata(duv_rdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_resp(rsp_resp), .rsp_data(rsp_data),
        .rsp_timeout(rsp_timeout), .stray_err(stray_err), .busy(busy)
    );

    always #5 c_clk = ~c_clk;

    // calc1 arithmetic: 1 add, 2 sub, 5 shl, 6 shr; overflow/underflow/unknown -> resp 2, data 0.
    function automatic logic [33:0] calc1(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
        logic [32:0] s;
        s = {1'b0, a} + {1'b0, b};
        case (c)
            4'd1:    calc1 = s[32] ? {2'd2, 32'd0} : {2'd1, s[31:0]};
            4'd2:    calc1 = (b > a) ? {2'd2, 32'd0} : {2'd1, a - b};
            4'd5:    calc1 = {2'd1, a << b[4:0]};
            4'd6:    calc1 = {2'd1, a >> b[4:0]};
            default: calc1 = {2'd2, 32'd0};
        endcase
    endfunction

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- calc1 responder ----------------
    bit silent = 0;
    bit rand_silent = 0;
    int stray_req = 0;
    int stray_ack = 0;
    int rs = 0;
    int rcnt = 0;
    logic [3:0]  r_c;
    logic [31:0] r_a, r_b;

    always @(posedge c_clk) begin
        #1;
        duv_resp  = '0;
        duv_rdata = '0;
        if (reset) rs = 0;
        else begin
            case (rs)
                0: begin
                    if (duv_cmd != 4'd0) begin
                        r_c = duv_cmd; r_a = duv_data; rs = 1;
                    end else if (stray_req != stray_ack) begin
                        stray_ack = stray_req; duv_resp = 2'd1;
                    end
                end
                1: begin
                    r_b = duv_data;
                    if (silent || (rand_silent && $urandom_range(0, 5) == 0)) rs = 0;
                    else begin rcnt = $urandom_range(1, 8); rs = 2; end
                end
                default: begin
                    rcnt--;
                    if (rcnt == 0) begin {duv_resp, duv_rdata} = calc1(r_c, r_a, r_b); rs = 0; end
                end
            endcase
        end
    end

    bit ready_mode = 0;
    always @(posedge c_clk) begin
        #1;
        rsp_ready = (ready_mode == 0) ? 1'b1 : ($urandom_range(0, 9) < 7);
    end

    // ---------------- transaction-level model + compare ----------------
    typedef struct packed { logic [3:0] c; logic [31:0] a; logic [31:0] b; } req_t;
    req_t        q[$];
    req_t        m_cur;
    bit          m_free = 1, m_wait = 0, m_op2_pend = 0, m_stray = 0;
    int          m_age = 0;
    logic [31:0] m_op2 = '0;
    logic [3:0]  e_cmd = '0;
    logic [31:0] e_dat = '0;
    bit          e_valid = 0, e_to = 0, e_new = 0;
    logic [1:0]  e_resp = '0;
    logic [31:0] e_rdat = '0;
    int          ncomp = 0;

    always @(negedge c_clk) begin
        req_t        r;
        logic [33:0] cr;
        bit          hs, old_free, win;
        if (reset) begin
            chk("rst_req_ready", req_ready, 1);
            chk("rst_busy", busy, 0);
            chk("rst_duv_cmd", duv_cmd, 0);
            chk("rst_duv_data", duv_data, 0);
            chk("rst_rsp_valid", rsp_valid, 0);
            chk("rst_rsp_resp", rsp_resp, 0);
            chk("rst_rsp_data", rsp_data, 0);
            chk("rst_rsp_timeout", rsp_timeout, 0);
            chk("rst_stray_err", stray_err, 0);
            q.delete();
            m_free = 1; m_wait = 0; m_op2_pend = 0; m_stray = 0; m_age = 0;
            e_cmd = '0; e_dat = '0; e_valid = 0; e_new = 0;
        end else begin
            chk("req_ready", req_ready, q.size() < DEPTH);
            chk("busy", busy, (q.size() != 0) || !m_free);
            chk("duv_cmd", duv_cmd, e_cmd);
            chk("duv_data", duv_data, e_dat);
            chk("rsp_valid", rsp_valid, e_valid);
            chk("stray_err", stray_err, m_stray);
            if (e_valid) begin
                chk("rsp_resp", rsp_resp, e_resp);
                chk("rsp_data", rsp_data, e_rdat);
                chk("rsp_timeout", rsp_timeout, e_to);
            end
            if (e_new) begin
                if (ncomp < NLIT) begin
                    chk($sformatf("lit%0d_resp", ncomp), rsp_resp, LIT_RESP[ncomp]);
                    chk($sformatf("lit%0d_data", ncomp), rsp_data, LIT_DATA[ncomp]);
                    chk($sformatf("lit%0d_timeout", ncomp), rsp_timeout, LIT_TO[ncomp]);
                end
                ncomp++;
                e_new = 0;
            end
            // advance the model to the next rising edge
            hs = e_valid && rsp_ready;
            old_free = m_free;
            e_cmd = '0; e_dat = '0;
            if (m_op2_pend) begin e_dat = m_op2; m_op2_pend = 0; end
            win = m_wait && (m_age >= 2) && (m_age <= TIMEOUT + 1);
            if ((duv_resp != 2'd0) && !win) m_stray = 1;
            if (m_wait) begin
                if (win && (duv_resp != 2'd0)) begin
                    cr = calc1(m_cur.c, m_cur.a, m_cur.b);
                    {e_resp, e_rdat} = cr; e_to = 0; e_valid = 1; e_new = 1; m_wait = 0;
                end else if (m_age == TIMEOUT + 1) begin
                    e_resp = '0; e_rdat = '0; e_to = 1; e_valid = 1; e_new = 1; m_wait = 0;
                end else m_age++;
            end
            if (hs) begin e_valid = 0; m_free = 1; end
            if (old_free && (q.size() != 0)) begin
                r = q.pop_front();
                if (r.c != 4'd0) begin
                    m_cur = r; m_free = 0; m_wait = 1; m_age = 0;
                    e_cmd = r.c; e_dat = r.a; m_op2 = r.b; m_op2_pend = 1;
                end
            end
            if (req_valid && (q.size() + (old_free && q.size() != 0 ? 1 : 0) < DEPTH + 0) && req_ready)
                q.push_back('{req_cmd, req_op1, req_op2});
        end
    end

    // ---------------- stimulus ----------------
    task automatic push(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
        int n = 0;
        req_valid = 1'b1; req_cmd = c; req_op1 = a; req_op2 = b;
        while (!req_ready) begin
            @(posedge c_clk); #1;
            n++;
            if (n > 500) begin
                $display("FAIL push_stall req_ready stuck at 0, required 1 within 500 cycles");
                $fatal(1);
            end
        end
        @(posedge c_clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (!((q.size() == 0) && m_free && !e_valid)) begin
            @(posedge c_clk); #1;
            n++;
            if (n > 400) begin
                $display("FAIL wait_idle model still busy=%0d, required idle within 400 cycles", !m_free);
                $fatal(1);
            end
        end
        repeat (2) @(posedge c_clk);
        #1;
    endtask

    logic [3:0] cmd_tab [8] = '{4'd0, 4'd1, 4'd2, 4'd5, 4'd6, 4'd1, 4'd2, 4'd9};

    initial begin
        repeat (3) @(posedge c_clk);
        #1 reset = 1'b0;
        push(4'd1, 32'h0000_0001, 32'h01FF_FFFF); wait_idle();
        push(4'd1, 32'hFFFF_FFFF, 32'h0000_0001); wait_idle();
        push(4'd2, 32'h0000_0001, 32'h0000_000F); wait_idle();
        push(4'd3, 32'h0000_0001, 32'h0000_0000); wait_idle();
        push(4'd4, 32'h0000_0001, 32'h0000_0000);
        for (int x = 0; x < 4; x++) push(4'd1, 32'(x), 32'(x + 1));
        wait_idle();
        silent = 1;
        push(4'd1, 32'd5, 32'd6); wait_idle();
        // reset while the driver sits in WAIT with two requests queued behind it
        push(4'd1, 32'd7, 32'd8);
        repeat (5) @(posedge c_clk);
        #1;
        push(4'd1, 32'd1, 32'd1);
        push(4'd2, 32'd3, 32'd1);
        reset = 1'b1;
        repeat (2) @(posedge c_clk);
        #1 reset = 1'b0;
        silent = 0;
        push(4'd0, 32'd9, 32'd9);
        repeat (12) @(posedge c_clk);
        #1;
        ready_mode = 1; rand_silent = 1;
        for (int i = 0; i < 250; i++) begin
            if ($urandom_range(0, 2) != 0)
                push(cmd_tab[$urandom_range(0, 7)], $urandom,
                     ($urandom_range(0, 1) != 0) ? $urandom : 32'($urandom_range(0, 40)));
            else begin
                @(posedge c_clk); #1;
            end
        end
        wait_idle();
        ready_mode = 0; rand_silent = 0;
        stray_req++;
        repeat (4) @(posedge c_clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
